// File: rtl/exec_unit_pkg.sv
// rtl/exec_unit_pkg.sv - op codes, FSM state type and helpers shared by the execute unit
package exec_unit_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
    localparam logic [OP_W-1:0] OP_AND   = 4'd2;
    localparam logic [OP_W-1:0] OP_OR    = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd4;
    localparam logic [OP_W-1:0] OP_NOR   = 4'd5;
    localparam logic [OP_W-1:0] OP_SLT   = 4'd6;
    localparam logic [OP_W-1:0] OP_SLTU  = 4'd7;
    localparam logic [OP_W-1:0] OP_SLL   = 4'd8;
    localparam logic [OP_W-1:0] OP_SRL   = 4'd9;
    localparam logic [OP_W-1:0] OP_SRA   = 4'd10;
    localparam logic [OP_W-1:0] OP_PASSA = 4'd11;
    localparam logic [OP_W-1:0] OP_BEQ   = 4'd12;
    localparam logic [OP_W-1:0] OP_BNE   = 4'd13;
    localparam logic [OP_W-1:0] OP_BGT   = 4'd14;
    localparam logic [OP_W-1:0] OP_BLE   = 4'd15;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic logic is_shift_op(input logic [OP_W-1:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/exec_unit_mc_shift_iter.sv
// rtl/exec_unit_mc_shift_iter.sv - iterative shifter, up to SHIFT_STEP bits per step
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   load_i          capture value_i/amount_i and the direction/mode bits
//   dir_right_i     1 = shift right, 0 = shift left
//   arith_i         1 = arithmetic right shift (sign fill)
//   value_i         value to be shifted
//   amount_i        total shift amount
//   step_i          perform one step of min(SHIFT_STEP, remaining) bits
//   last_o          the current step exhausts the remaining count
//   value_o         shift register value after the current step
module shift_iter
    import exec_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHAMT_W    = $clog2(WIDTH),
    parameter int SHIFT_STEP = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               dir_right_i,
    input  logic               arith_i,
    input  logic [WIDTH-1:0]   value_i,
    input  logic [SHAMT_W-1:0] amount_i,
    input  logic               step_i,
    output logic               last_o,
    output logic [WIDTH-1:0]   value_o
);

    localparam logic [SHAMT_W-1:0] STEP = SHAMT_W'(SHIFT_STEP);

    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               dir_right_q, dir_right_d;
    logic               arith_q, arith_d;
    logic [SHAMT_W-1:0] step_amt;
    logic [WIDTH-1:0]   shifted;

    // The final step may be shorter than SHIFT_STEP.
    assign step_amt = (cnt_q < STEP) ? cnt_q : STEP;
    assign last_o   = (cnt_q <= STEP);

    // Arithmetic right shift of the partially shifted register keeps the
    // original sign bit, since the MSB is never overwritten on the way.
    always_comb begin
        shifted = sreg_q;
        if (!dir_right_q) begin
            shifted = sreg_q << step_amt;
        end else if (arith_q) begin
            shifted = $unsigned($signed(sreg_q) >>> step_amt);
        end else begin
            shifted = sreg_q >> step_amt;
        end
    end

    assign value_o = shifted;

    always_comb begin
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        dir_right_d = dir_right_q;
        arith_d     = arith_q;
        if (load_i) begin
            sreg_d      = value_i;
            cnt_d       = amount_i;
            dir_right_d = dir_right_i;
            arith_d     = arith_i;
        end else if (step_i) begin
            sreg_d = shifted;
            cnt_d  = cnt_q - step_amt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q      <= '0;
            cnt_q       <= '0;
            dir_right_q <= 1'b0;
            arith_q     <= 1'b0;
        end else begin
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            dir_right_q <= dir_right_d;
            arith_q     <= arith_d;
        end
    end

endmodule

// File: rtl/exec_unit_mc.sv
// rtl/exec_unit_mc.sv - multicycle execute unit: ALU, compare, branch and iterative shifter
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start           request, sampled only in IDLE
//   op              operation code (exec_unit_pkg OP_*)
//   src_a, src_b    operands; src_b is also the shifted value
//   shamt           immediate shift amount
//   shift_var       1 = shift amount taken from src_b[SHAMT_W-1:0]
//   busy            high while a shift is iterating
//   done            one-cycle completion pulse
//   result, zero    registered result and result==0
//   overflow        signed overflow for ADD/SUB
//   branch_taken    branch condition for branch ops
module exec_unit_mc
    import exec_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHAMT_W    = $clog2(WIDTH),
    parameter int SHIFT_STEP = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               shift_var,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               overflow,
    output logic               branch_taken
);

    state_e           state_q, state_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             br_q, br_d;

    logic [WIDTH-1:0]   sum, diff;
    logic               add_ovf, sub_ovf;
    logic               lt_s, lt_u, eq;
    logic [SHAMT_W-1:0] amount;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf, alu_br;

    logic             sh_load, sh_step, sh_last;
    logic [WIDTH-1:0] sh_val;

    assign sum  = src_a + src_b;
    assign diff = src_a - src_b;

    // Overflow when both addends share a sign that the sum does not; for
    // subtraction the operands must differ in sign.
    assign add_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1]  != src_a[WIDTH-1]);
    assign sub_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);

    assign lt_s = $signed(src_a) < $signed(src_b);
    assign lt_u = src_a < src_b;
    assign eq   = (src_a == src_b);

    assign amount = shift_var ? src_b[SHAMT_W-1:0] : shamt;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_br  = 1'b0;
        case (op)
            OP_ADD:   begin alu_res = sum;  alu_ovf = add_ovf; end
            OP_SUB:   begin alu_res = diff; alu_ovf = sub_ovf; end
            OP_AND:   alu_res = src_a & src_b;
            OP_OR:    alu_res = src_a | src_b;
            OP_XOR:   alu_res = src_a ^ src_b;
            OP_NOR:   alu_res = ~(src_a | src_b);
            OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, lt_u};
            // Only reached for a zero shift amount; non-zero shifts iterate.
            OP_SLL, OP_SRL, OP_SRA: alu_res = src_b;
            OP_PASSA: alu_res = src_a;
            OP_BEQ:   begin alu_res = diff; alu_br = eq; end
            OP_BNE:   begin alu_res = diff; alu_br = !eq; end
            OP_BGT:   begin alu_res = diff; alu_br = !lt_s && !eq; end
            OP_BLE:   begin alu_res = diff; alu_br = lt_s || eq; end
            default:  alu_res = '0;
        endcase
    end

    shift_iter #(
        .WIDTH      (WIDTH),
        .SHAMT_W    (SHAMT_W),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift_iter (
        .clk         (clk),
        .reset       (reset),
        .load_i      (sh_load),
        .dir_right_i (op != OP_SLL),
        .arith_i     (op == OP_SRA),
        .value_i     (src_b),
        .amount_i    (amount),
        .step_i      (sh_step),
        .last_o      (sh_last),
        .value_o     (sh_val)
    );

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        br_d     = br_q;
        sh_load  = 1'b0;
        sh_step  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_shift_op(op) && (amount != '0)) begin
                        sh_load = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        done_d   = 1'b1;
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                        br_d     = alu_br;
                    end
                end
            end
            ST_SHIFT: begin
                sh_step = 1'b1;
                if (sh_last) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    result_d = sh_val;
                    zero_d   = (sh_val == '0);
                    ovf_d    = 1'b0;
                    br_d     = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            br_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            br_q     <= br_d;
        end
    end

    assign busy         = (state_q == ST_SHIFT);
    assign done         = done_q;
    assign result       = result_q;
    assign zero         = zero_q;
    assign overflow     = ovf_q;
    assign branch_taken = br_q;

endmodule

// File: doc/exec_unit_mc.md
Name: exec_unit_mc

Overview:
Parametrised multicycle execute unit for the multicycle datapath. It merges ALU arithmetic/logic, set-less-than, branch comparison and an iterative shifter behind one start/done handshake. Single-cycle ops complete on the accepting edge. Shifts run a programmable number of bits per cycle, so the control FSM can wait on done instead of hard-coding shift latency.

Parameters:
WIDTH, 32, datapath width (>=8).
SHAMT_W, $clog2(WIDTH), shift-amount width (5 at 32).
SHIFT_STEP, 1, max bits shifted per cycle (1..WIDTH-1).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high.
start  in  1  request; sampled only in IDLE.
op  in  4  operation code (see Behaviour).
src_a  in  WIDTH  operand A.
src_b  in  WIDTH  operand B; also the value that shifts operate on.
shamt  in  SHAMT_W  immediate shift amount.
shift_var  in  1  1 = shift amount is src_b[SHAMT_W-1:0] (shifted value stays src_b); 0 = shamt.
busy  out  1  high while a shift is iterating.
done  out  1  one-cycle completion pulse.
result  out  WIDTH  registered result, held until the next completion.
zero  out  1  result == 0, registered with result.
overflow  out  1  signed overflow (ADD/SUB only).
branch_taken  out  1  branch condition true (branch ops only).

Behaviour:
- Reset, synchronous and active-high: state IDLE; busy, done, result, zero, overflow and branch_taken all 0; shift register and counter 0. Reset has priority over everything. Reset mid-shift aborts the shift with no done pulse.
- op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU: result is zero-extended 1/0.
  - 8 SLL, 9 SRL, 10 SRA.
  - 11 PASSA: result = src_a.
  - 12 BEQ, 13 BNE, 14 BGT (signed A>B), 15 BLE (signed A<=B).
- Branch ops: result = A-B; branch_taken = condition. All other ops: branch_taken = 0.
- overflow is valid for ADD/SUB using standard two's-complement rules; 0 otherwise. All arithmetic wraps mod 2^WIDTH.
- FSM states: IDLE, SHIFT.
- IDLE, start=1, non-shift op: at the same edge (E0) latch result and flags, done=1 for that cycle, stay in IDLE. Latency 1; busy never rises.
- IDLE, start=1, shift op with amount k=0: same as a non-shift op; result = src_b.
- IDLE, start=1, shift op with k>0:
  - E0: load sreg=src_b and cnt=k, go to SHIFT, busy=1. Direction and arithmetic mode are latched.
  - Each later edge shifts sreg by min(SHIFT_STEP, cnt) and decrements cnt by that step.
  - On the edge where cnt reaches 0: result=shifted value, flags update, done=1, busy=0, go to IDLE.
  - Total shift edges n = ceil(k/SHIFT_STEP); done is visible after edge En.
- SRA fills with the sign bit of the original src_b; SLL and SRL fill with 0.
- start while busy=1 is ignored with no queueing. Operand and op changes during SHIFT have no effect.
- done is never high for two consecutive cycles unless a new start is accepted in the cycle done is high. Back-to-back single-cycle ops give consecutive done pulses.
- Outputs hold their last values between completions.

Decomposition:
- Package exec_unit_pkg holds:
  - op code localparams (OP_ADD..OP_BLE);
  - the state enum (ST_IDLE, ST_SHIFT);
  - helper function is_shift_op.
- Sub-module shift_iter (parameters WIDTH, SHAMT_W, SHIFT_STEP) owns sreg, cnt and the direction/mode latch. Interface: load, dir/mode, amount, step enable, last-step flag, value out.
- Top level holds the FSM, the combinational ALU/compare and the output registers.

Test Plan:
- ADD A=0x7FFFFFFF B=0x1 -> done at E0, result 0x80000000, overflow=1, zero=0, busy stays 0.
- SUB A=5 B=5 -> result 0, zero=1. BEQ A=5 B=5 -> branch_taken=1. BGT A=0xFFFFFFFF B=1 -> branch_taken=0.
- SRA B=0x80000000 shamt=4 (STEP=1) -> busy high after E0 through E3, done at E4, result 0xF8000000. Start(ADD) at E2 ignored.
- SLL k=0 -> done at E0, result=B. SLT A=0xFFFFFFFF B=1 -> 1. SLTU same operands -> 0. shift_var=1 with B=0x00000003 and SRL -> result 0x00000000 after 3 shift edges.
- SLL B=1 k=20, reset at E2 -> next cycle busy=0, done=0, result=0, no done pulse. Following ADD 2+3 -> result 5 at its E0.
- SHIFT_STEP=4 instance, SRL B=0xFFFFFFFF k=10 -> 3 shift edges (4,4,2), done at E3, result 0x003FFFFF.
